sdm_dac_bank: RTL and testbench

Parametrised multi-channel sigma-delta DAC bank, the next generation of the per-channel `sdm_modulator` instances in the audio top. It takes `NUM_CH` signed PCM streams through per-channel valid/ready handshakes and stages them into one-entry buffers. Staged samples are applied on a shared oversampling frame boundary. Each channel runs a runtime-selectable first- or second-order modulator and produces a 1-bit stream.

---
 rtl/sdm_pkg.sv | 42 ++++
 rtl/sdm_dac_channel.sv | 127 ++++++++++++
 rtl/sdm_dac_bank.sv | 123 ++++++++++++
 tb/tb_sdm_dac_bank.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdm_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : sdm_pkg                                                      |
// | Purpose : Shared types, constants and helpers for the sigma-delta DAC  |
// |           bank: modulator order encoding, integrator saturation and    |
// |           the dither LFSR seed/taps.                                   |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package sdm_pkg;

  typedef enum logic {
    SDM_ORDER1 = 1'b0,
    SDM_ORDER2 = 1'b1
  } sdm_order_e;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11 -> state bits 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Widest value sat_acc accepts; callers size-cast into and out of this.
  localparam int SAT_MAX_W = 64;

  // Clamp v to the signed range of a w-bit integer.
  function automatic logic signed [SAT_MAX_W-1:0] sat_acc(
    input logic signed [SAT_MAX_W-1:0] v,
    input int                          w
  );
    logic signed [SAT_MAX_W-1:0] hi;
    logic signed [SAT_MAX_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdm_dac_channel.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : sdm_dac_channel                                              |
// | Purpose : One DAC channel: one-entry staging buffer, active sample,    |
// |           first/second-order integrators and the 1-bit output.         |
// | Rev     : 1.0  initial release                                         |
// | Ports   : clk, rst_n        clock, async active-low reset              |
// |           tick              modulator advance strobe                   |
// |           boundary          frame boundary strobe (tick on last count) |
// |           clr_int           clear integrators instead of updating      |
// |           order             modulator order in effect this tick        |
// |           mute              force modulator input to zero              |
// |           dith_en/dith_bit  +/-1 LSB dither on the modulator input     |
// |           clear_status      clear the underrun flag                    |
// |           in_valid/in_ready/din  sample handshake into staging buffer  |
// |           dout              registered bitstream output                |
// |           underrun          sticky empty-at-boundary flag              |
// +------------------------------------------------------------------------+
module sdm_dac_channel
  import sdm_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = DATA_W + 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              boundary,
  input  logic              clr_int,
  input  sdm_order_e        order,
  input  logic              mute,
  input  logic              dith_en,
  input  logic              dith_bit,
  input  logic              clear_status,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] din,
  output logic              dout,
  output logic              underrun
);

  // Two guard bits so i + x - fb can never wrap before saturation.
  localparam int SUM_W = ACC_W + 2;
  localparam logic signed [SUM_W-1:0] ONE    = SUM_W'(1);
  localparam logic signed [SUM_W-1:0] FB_POS = ONE <<< (DATA_W - 1);
  localparam logic signed [SUM_W-1:0] FB_NEG = -FB_POS;

  logic signed [DATA_W-1:0] stage;
  logic signed [DATA_W-1:0] active;
  logic                     stage_full;
  logic signed [ACC_W-1:0]  i1;
  logic signed [ACC_W-1:0]  i2;

  logic signed [SUM_W-1:0]  x;
  logic signed [SUM_W-1:0]  fb;
  logic signed [SUM_W-1:0]  s1;
  logic signed [SUM_W-1:0]  s2;
  logic signed [ACC_W-1:0]  i1_n;
  logic signed [ACC_W-1:0]  i2_n;
  logic signed [ACC_W-1:0]  sel;
  logic                     dout_n;

  assign in_ready = !stage_full;

  always_comb begin
    x = mute ? '0 : SUM_W'(active);
    if (dith_en) begin
      x = x + (dith_bit ? ONE : -ONE);
    end
    fb = dout ? FB_POS : FB_NEG;

    s1   = SUM_W'(i1) + x - fb;
    i1_n = ACC_W'(sat_acc(SAT_MAX_W'(s1), ACC_W));
    s2   = SUM_W'(i2) + SUM_W'(i1_n) - fb;
    // First-order mode leaves i2 untouched.
    i2_n = (order == SDM_ORDER2) ? ACC_W'(sat_acc(SAT_MAX_W'(s2), ACC_W)) : i2;

    // An order change restarts both integrators from zero on that tick.
    if (clr_int) begin
      i1_n = '0;
      i2_n = '0;
    end

    sel    = (order == SDM_ORDER2) ? i2_n : i1_n;
    dout_n = ~sel[ACC_W-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage      <= '0;
      active     <= '0;
      stage_full <= 1'b0;
      i1         <= '0;
      i2         <= '0;
      dout       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      if (boundary && stage_full) begin
        active <= stage;
      end

      // An accept is only possible while empty, so it never collides with
      // the boundary hand-off of a full buffer.
      if (in_valid && !stage_full) begin
        stage      <= din;
        stage_full <= 1'b1;
      end else if (boundary) begin
        stage_full <= 1'b0;
      end

      // Set has priority over clear.
      if (boundary && !stage_full) begin
        underrun <= 1'b1;
      end else if (clear_status) begin
        underrun <= 1'b0;
      end

      if (tick) begin
        i1   <= i1_n;
        i2   <= i2_n;
        dout <= dout_n;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sdm_dac_bank.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : sdm_dac_bank                                                 |
// | Purpose : NUM_CH-channel sigma-delta DAC bank. Samples are staged per  |
// |           channel and applied together on a shared OSR-tick frame      |
// |           boundary; each channel runs a first/second-order modulator.  |
// | Rev     : 1.0  initial release                                         |
// | Config  : SDM_DAC_BANK_DITHER_EN - when defined, a shared 16-bit LFSR  |
// |           adds +/-1 LSB dither to every channel's modulator input.     |
// | Ports   : clk, rst_n        clock, async active-low reset              |
// |           tick              modulator advance strobe                   |
// |           order_sel         0 first order, 1 second order (at boundary)|
// |           mute              zero modulator input on ticks              |
// |           clear_status      clear underrun flags                       |
// |           in_valid/in_ready/din  per-channel sample handshakes         |
// |           out_valid         tick delayed by one cycle                  |
// |           dout              per-channel bitstreams                     |
// |           underrun          per-channel sticky underrun flags          |
// +------------------------------------------------------------------------+
module sdm_dac_bank
  import sdm_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 16,
  parameter int OSR    = 64,
  parameter int ACC_W  = DATA_W + 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tick,
  input  logic                     order_sel,
  input  logic                     mute,
  input  logic                     clear_status,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*DATA_W-1:0] din,
  output logic                     out_valid,
  output logic [NUM_CH-1:0]        dout,
  output logic [NUM_CH-1:0]        underrun
);

  localparam int               CNT_W    = $clog2(OSR);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);

  logic [CNT_W-1:0]  cnt;
  sdm_order_e        order_q;
  sdm_order_e        order_in;
  logic              boundary;
  logic              clr_int;
  logic [NUM_CH-1:0] dith_bits;
  logic              dith_en;

  assign order_in = sdm_order_e'(order_sel);
  assign boundary = tick && (cnt == CNT_LAST);
  assign clr_int  = boundary && (order_in != order_q);

  // OSR is a power of two, so the counter wraps on its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      order_q   <= SDM_ORDER1;
      out_valid <= 1'b0;
    end else begin
      out_valid <= tick;
      if (tick) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (boundary) begin
        order_q <= order_in;
      end
    end
  end

`ifdef SDM_DAC_BANK_DITHER_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else if (tick) begin
      lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end
  end

  assign dith_en = 1'b1;
`else
  assign dith_en = 1'b0;
`endif

  genvar k;
  generate
    for (k = 0; k < NUM_CH; k++) begin : g_ch
`ifdef SDM_DAC_BANK_DITHER_EN
      assign dith_bits[k] = lfsr[k % 16];
`else
      assign dith_bits[k] = 1'b0;
`endif

      sdm_dac_channel #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_ch (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .boundary     (boundary),
        .clr_int      (clr_int),
        .order        (order_q),
        .mute         (mute),
        .dith_en      (dith_en),
        .dith_bit     (dith_bits[k]),
        .clear_status (clear_status),
        .in_valid     (in_valid[k]),
        .in_ready     (in_ready[k]),
        .din          (din[k*DATA_W +: DATA_W]),
        .dout         (dout[k]),
        .underrun     (underrun[k])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sdm_dac_bank.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_sdm_dac_bank                                              |
// | Purpose : Scoreboard bench for sdm_dac_bank. Every issued tick pushes  |
// |           the expected dout (with a care mask) into a queue; a monitor |
// |           pops one entry per out_valid. Densities are accumulated by   |
// |           the monitor for entries flagged as counted.                  |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_sdm_dac_bank;
  import sdm_pkg::*;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 16;
  localparam int OSR    = 8;
  localparam int ACC_W  = DATA_W + 4;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     tick = 1'b0;
  logic                     order_sel = 1'b0;
  logic                     mute = 1'b0;
  logic                     clear_status = 1'b0;
  logic [NUM_CH-1:0]        in_valid = '0;
  logic [NUM_CH-1:0]        in_ready;
  logic [NUM_CH*DATA_W-1:0] din = '0;
  logic                     out_valid;
  logic [NUM_CH-1:0]        dout;
  logic [NUM_CH-1:0]        underrun;

  sdm_dac_bank #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .OSR    (OSR),
    .ACC_W  (ACC_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .order_sel    (order_sel),
    .mute         (mute),
    .clear_status (clear_status),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .din          (din),
    .out_valid    (out_valid),
    .dout         (dout),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_CH-1:0] mask;
    logic [NUM_CH-1:0] exp;
    bit                count;
    string             name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   passed = 0;
  int   total  = 0;
  int   ones[NUM_CH];
  int   bcnt = 0;
  int   gt   = 0;
  int   acc  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act >= lo && act <= hi) passed++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  // Issue one tick and queue what dout must look like one cycle later.
  task automatic do_tick(input logic [NUM_CH-1:0] mask, input logic [NUM_CH-1:0] expv,
                         input bit cnt_en, input string name);
    exp_t e;
    e.mask  = mask;
    e.exp   = expv;
    e.count = cnt_en;
    e.name  = name;
    sb.push_back(e);
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    bcnt = (bcnt + 1) % OSR;
  endtask

  task automatic idle_tick();
    gt++;
    do_tick('1, (gt == 1 || gt % 2 == 0) ? {NUM_CH{1'b1}} : '0, 1'b0, "idle dout");
  endtask

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    @(negedge clk); #1;
  endtask

  task automatic clear_ones();
    for (int k = 0; k < NUM_CH; k++) ones[k] = 0;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      check("out_valid has matching tick", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        if (mon_e.count) begin
          for (int k = 0; k < NUM_CH; k++) ones[k] += int'(dout[k]);
        end
        if (mon_e.mask != '0) begin
          check(mon_e.name, 32'(dout & mon_e.mask), 32'(mon_e.exp & mon_e.mask));
        end
      end
    end
  end

  logic izero;

  initial begin
    clear_ones();
    // Reset values while held in reset.
    #2;
    check("reset dout", 32'(dout), 32'h0);
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset underrun", 32'(underrun), 32'h0);
    check("reset in_ready", 32'(in_ready), 32'hF);
    cycle(); cycle();
    rst_n = 1'b1;
    cycle();

    // Idle first-order stream: 1,1 then alternating 0,1; underrun on tick OSR.
    for (int i = 0; i < OSR - 1; i++) idle_tick();
    check("underrun before boundary", 32'(underrun), 32'h0);
    idle_tick();
    check("underrun at tick OSR", 32'(underrun), 32'hF);
    clear_status = 1'b1;
    cycle();
    clear_status = 1'b0;
    check("clear_status clears", 32'(underrun), 32'h0);
    for (int i = 0; i < OSR - 1; i++) idle_tick();
    clear_status = 1'b1;
    idle_tick();
    clear_status = 1'b0;
    check("set wins over clear", 32'(underrun), 32'hF);

    // Mid-stream asynchronous reset after a partial accept.
    in_valid = '1;
    din      = {4{16'h1234}};
    cycle();
    in_valid = '0;
    do_tick('0, '0, 1'b0, "pre-reset");
    check("in_ready low before reset", 32'(in_ready), 32'h0);
    rst_n = 1'b0;
    #1;
    check("async reset dout", 32'(dout), 32'h0);
    check("async reset out_valid", 32'(out_valid), 32'h0);
    check("async reset underrun", 32'(underrun), 32'h0);
    check("async reset in_ready", 32'(in_ready), 32'hF);
    sb.delete();
    cycle(); cycle();
    rst_n = 1'b1;
    bcnt = 0;
    gt   = 0;
    din  = '0;
    cycle();

    // Handshake on ch2 held valid: one accept per frame, ready one cycle
    // after each boundary. Then first-order density with 0x4000 -> 0.75.
    in_valid = 4'b0100;
    din[2*DATA_W +: DATA_W] = 16'h4000;
    check("ready before accept", 32'(in_ready), 32'hF);
    cycle();
    check("ready after accept", 32'(in_ready), 32'hB);
    acc = 0;
    for (int i = 1; i <= 88; i++) begin
      check("ch2 in_ready", 32'(in_ready[2]), 32'((i > 1) && ((i - 1) % OSR == 0)));
      if (in_valid[2] && in_ready[2]) acc++;
      if (i == 25) clear_ones();
      do_tick('0, '0, i > 24, "");
    end
    drain();
    check("ch2 accepts per frame", 32'(acc), 32'd10);
    check_range("ch2 density 0x4000", ones[2], 46, 50);

    // Mute: same sample, density falls to 0.5.
    mute = 1'b1;
    for (int i = 0; i < OSR; i++) do_tick('0, '0, 1'b0, "");
    drain();
    clear_ones();
    for (int i = 0; i < 64; i++) do_tick('0, '0, 1'b1, "");
    drain();
    check_range("ch2 density muted", ones[2], 30, 34);
    mute = 1'b0;

    // Skip frames on ch2: full stage covers one boundary, the next underruns.
    clear_status = 1'b1;
    cycle();
    clear_status = 1'b0;
    in_valid = '0;
    check("underrun cleared", 32'(underrun), 32'h0);
    while (bcnt != OSR - 1) do_tick('0, '0, 1'b0, "");
    do_tick('0, '0, 1'b0, "");
    check("ch2 staged covers boundary", 32'(underrun), 32'hB);
    for (int i = 0; i < OSR; i++) do_tick('0, '0, 1'b0, "");
    check("ch2 skipped frame", 32'(underrun), 32'hF);
    clear_status = 1'b1;
    cycle();
    clear_status = 1'b0;
    check("ch2 underrun cleared", 32'(underrun), 32'h0);

    // Order switch mid-frame: order_q moves only on the boundary tick and
    // that tick leaves every integrator at zero.
    while (bcnt != 3) do_tick('0, '0, 1'b0, "");
    order_sel = 1'b1;
    while (bcnt != OSR - 1) do_tick('0, '0, 1'b0, "");
    check("order_q before boundary", 32'(dut.order_q), 32'(SDM_ORDER1));
    do_tick('0, '0, 1'b0, "");
    check("order_q after boundary", 32'(dut.order_q), 32'(SDM_ORDER2));
    izero = (dut.g_ch[0].u_ch.i1 == '0) && (dut.g_ch[0].u_ch.i2 == '0) &&
            (dut.g_ch[1].u_ch.i1 == '0) && (dut.g_ch[1].u_ch.i2 == '0) &&
            (dut.g_ch[2].u_ch.i1 == '0) && (dut.g_ch[2].u_ch.i2 == '0) &&
            (dut.g_ch[3].u_ch.i1 == '0) && (dut.g_ch[3].u_ch.i2 == '0);
    check("integrators cleared", 32'(izero), 32'd1);

    // Full scale, second order: ch0 +max -> almost all ones, ch1 -max -> almost none.
    in_valid = 4'b0011;
    din[0*DATA_W +: DATA_W] = 16'h7FFF;
    din[1*DATA_W +: DATA_W] = 16'h8000;
    cycle();
    in_valid = '0;
    check("full-scale accept", 32'(in_ready), 32'hC);
    while (bcnt != OSR - 1) do_tick('0, '0, 1'b0, "");
    do_tick('0, '0, 1'b0, "");
    drain();
    clear_ones();
    for (int i = 0; i < 4096; i++) do_tick('0, '0, 1'b1, "");
    drain();
    check_range("ch0 density +full", ones[0], 4056, 4096);
    check_range("ch1 density -full", ones[1], 0, 40);

    cycle(); cycle();
    check("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
